// File: rtl/data_memory_arbiter.sv
// Single-bank data memory arbiter: CPU-priority access with DMA starvation relief and locked DMA bursts.
// Read data returns one cycle after the grant, aligned with the synchronous-read bank.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ARB      | normal arbitration, CPU wins unless DMA has waited MAX_WAIT
//  BURST    | DMA owns the port for a locked burst, CPU always stalled
//  CPU_SLOT | one guaranteed CPU opportunity after a burst
module data_memory_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        BURST    = 2'd1,
        CPU_SLOT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              cpu_rvalid_q, dma_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
    logic              starved;
    logic              burst_more;

    assign starved = (starve_q == SW'(MAX_WAIT));
    // burst_q counts grants already issued; the grant taken now is the last one when it reaches MAX_BURST-1
    assign burst_more = dma_req && dma_lock && (burst_q < BW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        unique case (state_q)
            ARB: begin
                if (dma_req && (!cpu_req || starved)) begin
                    dma_gnt = 1'b1;
                    if (dma_lock) begin
                        state_d = BURST;
                        burst_d = BW'(1);
                    end
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end
            end
            BURST: begin
                dma_gnt = dma_req;
                if (burst_more) begin
                    burst_d = burst_q + BW'(1);
                end else begin
                    burst_d = '0;
                    state_d = cpu_req ? CPU_SLOT : ARB;
                end
            end
            CPU_SLOT: begin
                cpu_gnt = cpu_req;
                state_d = ARB;
            end
            default: begin
                state_d = ARB;
                burst_d = '0;
            end
        endcase
        if (!reset) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end
    end

    always_comb begin
        starve_d = '0;
        if (dma_req && !dma_gnt) begin
            starve_d = starved ? starve_q : starve_q + SW'(1);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_stall  = cpu_req && !cpu_gnt;
    // a read whose return cycle falls inside reset is dropped
    assign cpu_rvalid = cpu_rvalid_q && reset;
    assign dma_rvalid = dma_rvalid_q && reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ARB;
            starve_q     <= '0;
            burst_q      <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            burst_q      <= burst_d;
            cpu_rvalid_q <= cpu_gnt && !cpu_we;
            dma_rvalid_q <= dma_gnt && !dma_we;
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (dma_rvalid) dma_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed arbitration sequences with a read-data scoreboard
// against a synchronous-read memory model.
module tb_data_memory_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_gnt, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_rdata;
    logic       dma_req, dma_we, dma_lock;
    logic [7:0] dma_addr, dma_wdata;
    logic       dma_gnt, dma_rvalid;
    logic [7:0] dma_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] cq[$];
    logic [7:0] dq[$];
    logic [7:0] gold [256];
    logic [7:0] mem  [256];
    logic       mem_ready = 1'b0;

    data_memory_arbiter #(
        .ADDR_W(8), .DATA_W(8), .MAX_WAIT(4), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        return (i == 16) ? 8'h5A : (8'(i) ^ 8'hA5);
    endfunction

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cpu_rvalid === 1'b1) begin
            if (cq.size() == 0) check_val("cpu_rvalid_unexpected", 32'(cpu_rvalid), 32'd0);
            else check_val("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
        end
        if (dma_rvalid === 1'b1) begin
            if (dq.size() == 0) check_val("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
            else check_val("dma_rdata", 32'(dma_rdata), 32'(dq.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr, input logic [7:0] cwd,
                         input logic dreq, input logic dwe, input logic dlock, input logic [7:0] daddr,
                         input logic [7:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_lock = dlock; dma_addr = daddr; dma_wdata = dwd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #3;
        check_val("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        check_val("idle_dma_gnt", 32'(dma_gnt), 32'd0);
        check_val("idle_mem_addr", 32'(mem_addr), 32'd0);
        tick();
    endtask

    initial begin
        logic       exp_c, exp_d, lk, dr;
        logic [7:0] da;

        for (int i = 0; i < 256; i++) gold[i] = init_val(i);
        reset = 1'b0;
        drive(1, 1, 8'h33, 8'h44, 1, 0, 1, 8'h55, 8'h00);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            #3;
            check_val("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
            check_val("rst_dma_gnt", 32'(dma_gnt), 32'd0);
            check_val("rst_mem_we", 32'(mem_we), 32'd0);
            check_val("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            check_val("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
            tick();
        end
        reset = 1'b1;
        idle();
        check_val("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);

        // CPU-only read of 0x10
        drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #3;
        check_val("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_val("rd_cpu_stall", 32'(cpu_stall), 32'd0);
        check_val("rd_mem_addr", 32'(mem_addr), 32'h10);
        check_val("rd_mem_we", 32'(mem_we), 32'd0);
        cq.push_back(gold[16]);
        tick();
        drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        #3;
        check_val("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        tick();
        idle();
        check_val("rd_cpu_rdata_hold", 32'(cpu_rdata), 32'h5A);
        check_val("rd_cpu_rvalid_low", 32'(cpu_rvalid), 32'd0);

        // simultaneous writes: CPU first, DMA on the following cycle
        drive(1, 1, 8'h01, 8'h11, 1, 1, 0, 8'h02, 8'h22);
        #3;
        check_val("wr_mem_we", 32'(mem_we), 32'd1);
        check_val("wr_mem_addr", 32'(mem_addr), 32'h01);
        check_val("wr_mem_wdata", 32'(mem_wdata), 32'h11);
        check_val("wr_dma_gnt", 32'(dma_gnt), 32'd0);
        check_val("wr_cpu_stall", 32'(cpu_stall), 32'd0);
        gold[1] = 8'h11;
        tick();
        drive(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h02, 8'h22);
        #3;
        check_val("wr_dma_gnt2", 32'(dma_gnt), 32'd1);
        check_val("wr_mem_addr2", 32'(mem_addr), 32'h02);
        check_val("wr_mem_wdata2", 32'(mem_wdata), 32'h22);
        gold[2] = 8'h22;
        tick();
        idle();

        // both reading continuously: DMA forced in every fifth cycle
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
            #3;
            exp_d = ((k % 5) == 4);
            check_val("fair_cpu_gnt", 32'(cpu_gnt), 32'(!exp_d));
            check_val("fair_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            check_val("fair_cpu_stall", 32'(cpu_stall), 32'(exp_d));
            if (exp_d) dq.push_back(gold[2]);
            else cq.push_back(gold[1]);
            tick();
        end
        idle();

        // locked DMA burst against a held CPU request
        da = 8'h20;
        for (int k = 0; k < 13; k++) begin
            drive(1, 0, 8'h10, 8'h00, 1, 0, 1, da, 8'h00);
            #3;
            exp_d = (k >= 4) && (k <= 11);
            exp_c = (k < 4) || (k == 12);
            check_val("burst_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
            check_val("burst_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            check_val("burst_cpu_stall", 32'(cpu_stall), 32'(!exp_c));
            check_val("burst_mem_addr", 32'(mem_addr), exp_d ? 32'(da) : 32'h10);
            if (exp_c) cq.push_back(gold[16]);
            if (exp_d) dq.push_back(gold[da]);
            tick();
            if (exp_d) da = da + 8'd1;
        end
        idle();

        // lock released after three burst grants
        for (int k = 0; k < 9; k++) begin
            lk = (k < 7);
            dr = (k < 8);
            drive(1, 0, 8'h01, 8'h00, dr, 0, lk, 8'h30, 8'h00);
            #3;
            exp_d = (k >= 4) && (k <= 7);
            exp_c = (k < 4) || (k == 8);
            check_val("unlock_cpu_gnt", 32'(cpu_gnt), 32'(exp_c));
            check_val("unlock_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            if (exp_c) cq.push_back(gold[1]);
            if (exp_d) dq.push_back(gold[48]);
            tick();
        end
        idle();

        // reset during a burst with a read in flight
        drive(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h40, 8'h00);
        #3;
        check_val("rstb_dma_gnt0", 32'(dma_gnt), 32'd1);
        dq.push_back(gold[64]);
        tick();
        drive(0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h41, 8'h00);
        #3;
        check_val("rstb_dma_gnt1", 32'(dma_gnt), 32'd1);
        tick();
        reset = 1'b0;
        drive(1, 1, 8'h05, 8'h77, 1, 0, 1, 8'h42, 8'h00);
        #3;
        check_val("rstb_cpu_gnt_in", 32'(cpu_gnt), 32'd0);
        check_val("rstb_dma_gnt_in", 32'(dma_gnt), 32'd0);
        check_val("rstb_mem_we_in", 32'(mem_we), 32'd0);
        check_val("rstb_dma_rvalid_in", 32'(dma_rvalid), 32'd0);
        tick();
        reset = 1'b1;
        drive(1, 0, 8'h05, 8'h00, 1, 0, 1, 8'h42, 8'h00);
        #3;
        check_val("rstb_cpu_gnt", 32'(cpu_gnt), 32'd1);
        check_val("rstb_dma_gnt", 32'(dma_gnt), 32'd0);
        check_val("rstb_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        check_val("rstb_dma_rvalid", 32'(dma_rvalid), 32'd0);
        cq.push_back(gold[5]);
        tick();
        idle();
        idle();

        check_val("cpu_queue_empty", 32'(cq.size()), 32'd0);
        check_val("dma_queue_empty", 32'(dq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
